data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the processor's load/store/fetch port; it is the other end of
//  the initiator interface the processor drives.
//  Accepts one request at a time over a valid/ready handshake and applies WAIT_CYCLES of
//  programmable latency. Performs a byte-strobed word write or a word read on local storage.
//  Returns one response per request over a second valid/ready handshake.
//  Sits beside processorModule in the top-level and in processor benches.
// PARAMETERS
//  DATA_W       32   data word width, bits (multiple of 8)
//  ADDR_W       32   byte-address width
//  DEPTH        256  number of DATA_W words of storage
//  WAIT_CYCLES  2    extra latency cycles between accept and access (0 legal)
// PORTS
//  clk         in   1         clock, all state on rising edge
//  reset       in   1         asynchronous, active-low reset (0 = in reset)
//  req_valid   in   1         request present
//  req_ready   out  1         responder can accept a request this cycle
//  req_we      in   1         1 = write, 0 = read
//  req_addr    in   ADDR_W    byte address
//  req_wdata   in   DATA_W    write data
//  req_wstrb   in   DATA_W/8  byte-enable, bit i covers wdata[8i+7:8i]
//  resp_valid  out  1         response present
//  resp_ready  in   1         initiator takes response this cycle
//  resp_rdata  out  DATA_W    read data (0 for writes and errors)
//  resp_err    out  1         request was misaligned or out of range
// BEHAVIOUR
//  - States: IDLE, WAIT, RESP; reset value is IDLE.
//  - Reset (reset==0, async): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0.
//    req_ready rises on the first clk edge after reset release. Storage contents are NOT reset.
//  - req_ready = 1 only in IDLE. Accept = req_valid & req_ready at edge T.
//    On accept, latch we/addr/wdata/wstrb; cnt <= WAIT_CYCLES; go to WAIT.
//  - WAIT: cnt!=0 -> cnt-1. When cnt==0, do the access and go to RESP on that edge.
//    resp_valid is therefore first high after edge T+1+WAIT_CYCLES.
//  - Address check: idx = addr[ADDR_W-1:2]. Request is an error if addr[1:0]!=0 or idx>=DEPTH.
//    Error: no write, resp_rdata=0, resp_err=1.
//  - Write: mem[idx] byte i <= wdata byte i where wstrb[i]=1; other bytes unchanged.
//    resp_rdata=0, resp_err=0. wstrb==0 is legal (no change, normal response).
//  - Read: resp_rdata=mem[idx], resp_err=0.
//  - RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_valid & resp_ready.
//    On that edge go to IDLE and drop resp_valid. req_ready=1 in the following cycle.
//  - No accept while WAIT or RESP; req_* changes in those states are ignored.
//  - Read of a word written by an earlier request returns the new value. Writes commit only
//    at the access edge.
//  - Reset mid-operation aborts the request. A write not yet at its access edge is never
//    committed, and no response is produced for the aborted request.
//  - cnt width: $clog2(WAIT_CYCLES+1), minimum 1 bit; no wrap (loaded, counts down to 0).
// STRUCTURE
//  - Shared include/package mem_if_defs: state encodings (IDLE/WAIT/RESP) and WORD_BYTES.
//    Also an ERR_NONE/ERR_ADDR response-code define, reused by the processor-side master.
//  - One sub-module, mem_word_array: DEPTH x DATA_W storage with a byte-strobe write port
//    and an async read port.
//  - The FSM, counter, address check and response registers stay in data_mem_responder.
// TESTING
//  - Reset: hold reset=0 then release.
//    -> resp_valid=0, resp_err=0, resp_rdata=0 during reset; req_ready=1 after the first edge.
//  - Write then read: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x10.
//    -> rdata 0xDEADBEEF, err 0; with WAIT_CYCLES=2, resp_valid is high 3 edges after accept.
//  - Byte strobe: after the above, write 0x10, wdata 0x11223344, wstrb 4'b0101, then read.
//    -> rdata 0xDE22BE44.
//  - Errors: read 0x13 -> err 1, rdata 0. Read 4*DEPTH -> err 1. Write 4*DEPTH -> no
//    storage change (check by re-reading 0x10).
//  - Backpressure: hold resp_ready=0 for 5 cycles, toggling req_valid/req_addr meanwhile.
//    -> resp_valid and data stable, req_ready=0 throughout, exactly one response.
//  - Abort and zero latency: reset=0 during WAIT of a write to 0x20 holding 0.
//    -> a later read of 0x20 returns 0. Repeat with WAIT_CYCLES=0 -> resp_valid on edge T+1.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared memory-interface definitions: responder state encoding, word geometry and
// response codes used by both the memory responder and the processor-side initiator.
package mem_if_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int OFFS_W     = $clog2(WORD_BYTES);

    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_ADDR = 1'b1;

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// Word-organised storage with a byte-strobed synchronous write port and an asynchronous
// read port sharing one word index. Contents are deliberately not reset.
module mem_word_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Only strobed byte lanes are written; unstrobed lanes keep their old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one request at a time, waits WAIT_CYCLES, performs a
// byte-strobed write or word read on local storage, and returns one response.
module data_mem_responder
    import mem_if_defs::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = ADDR_W - OFFS_W;
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES);
    localparam logic [WIDX_W-1:0] DEPTH_IDX = WIDX_W'(DEPTH);

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic                ready_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    logic                accept;
    logic                access;
    logic                addr_err;
    logic                mem_we;
    logic [WIDX_W-1:0]   word_idx;
    logic [DATA_W-1:0]   mem_rdata;

    assign word_idx   = addr_q[ADDR_W-1:OFFS_W];
    assign addr_err   = (addr_q[OFFS_W-1:0] != '0) || (word_idx >= DEPTH_IDX);
    assign mem_we     = access && we_q && !addr_err;
    assign req_ready  = ready_q;
    assign resp_valid = (state == RESP);

    mem_word_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .idx    (word_idx[IDX_W-1:0]),
        .wdata  (wdata_q),
        .wstrb  (wstrb_q),
        .rdata  (mem_rdata)
    );

    // Next-state logic; the access happens on the edge that leaves WAIT.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && ready_q) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // req_ready is registered so it stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= ERR_NONE;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE);

            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                cnt     <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (access) begin
                resp_err   <= addr_err ? ERR_ADDR : ERR_NONE;
                resp_rdata <= (addr_err || we_q) ? '0 : mem_rdata;
            end else if (state == RESP && resp_ready) begin
                resp_err   <= ERR_NONE;
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed and randomized transactions on a WAIT_CYCLES=2
// and a zero-latency instance, checked against a word-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int W_A   = 2;
    localparam int W_B   = 0;

    logic        clk;
    logic        reset;
    logic        a_req_valid;
    logic        b_req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;

    logic        a_req_ready, b_req_ready;
    logic        a_resp_valid, b_resp_valid;
    logic [31:0] a_resp_rdata, b_resp_rdata;
    logic        a_resp_err, b_resp_err;

    int checks;
    int failures;

    logic [31:0] model_a [DEPTH];
    logic [31:0] model_b [DEPTH];

    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W_A)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (a_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err)
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W_B)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (b_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ready(input int sel);
        return (sel != 0) ? b_req_ready : a_req_ready;
    endfunction

    function automatic logic cur_rv(input int sel);
        return (sel != 0) ? b_resp_valid : a_resp_valid;
    endfunction

    function automatic logic [31:0] cur_rdata(input int sel);
        return (sel != 0) ? b_resp_rdata : a_resp_rdata;
    endfunction

    function automatic logic cur_err(input int sel);
        return (sel != 0) ? b_resp_err : a_resp_err;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) b_req_valid = v;
        else          a_req_valid = v;
    endtask

    // Reference behaviour: alignment/range rule, byte-lane merge, read returns stored word.
    task automatic model_op(input int sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] exp_rdata, output logic exp_err);
        logic [31:0] word;
        int          widx;
        exp_err   = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            widx = int'(addr / 4);
            word = (sel != 0) ? model_b[widx] : model_a[widx];
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb[i]) word[8*i +: 8] = wdata[8*i +: 8];
                end
                if (sel != 0) model_b[widx] = word;
                else          model_a[widx] = word;
            end else begin
                exp_rdata = word;
            end
        end
    endtask

    task automatic do_txn(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cur_ready(sel) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_before_accept", 32'(cur_ready(sel)), 32'h1);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        set_valid(sel, 1'b1);
        @(posedge clk);
        #1;
        set_valid(sel, 1'b0);
        req_addr = $urandom;
        req_we   = 1'($urandom);
        lat = 0;
        while (!cur_rv(sel) && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_valid_arrives", 32'(cur_rv(sel)), 32'h1);
        rdata = cur_rdata(sel);
        err   = cur_err(sel);
        for (int h = 0; h < hold; h++) begin
            set_valid(sel, 1'($urandom));
            req_addr = $urandom;
            @(posedge clk);
            #1;
            check("bp_resp_valid", 32'(cur_rv(sel)), 32'h1);
            check("bp_rdata_stable", cur_rdata(sel), rdata);
            check("bp_err_stable", 32'(cur_err(sel)), 32'(err));
            check("bp_req_ready_low", 32'(cur_ready(sel)), 32'h0);
        end
        set_valid(sel, 1'b0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("resp_dropped", 32'(cur_rv(sel)), 32'h0);
        check("req_ready_returns", 32'(cur_ready(sel)), 32'h1);
    endtask

    task automatic applyStimulus(input int sel, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input int hold, output logic [31:0] rdata);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        err;
        int          lat;
        model_op(sel, we, addr, wdata, wstrb, exp_rdata, exp_err);
        do_txn(sel, we, addr, wdata, wstrb, hold, rdata, err, lat);
        check("rdata", rdata, exp_rdata);
        check("err", 32'(err), 32'(exp_err));
        check("latency", 32'(lat), 32'(((sel != 0) ? W_B : W_A) + 1));
    endtask

    function automatic logic [31:0] pick_addr(input int lo, input int hi);
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 32'(lo * 4 + int'($urandom_range(1, 3)));
        if (r == 1) return 32'(4 * DEPTH + 4 * int'($urandom_range(0, 8)));
        if (r == 2) return 32'hFFFF_FFFC;
        return 32'(4 * int'($urandom_range(lo, hi)));
    endfunction

    initial begin
        logic [31:0] rd;
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        resp_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_a_resp_valid", 32'(a_resp_valid), 32'h0);
        check("rst_a_resp_err", 32'(a_resp_err), 32'h0);
        check("rst_a_resp_rdata", a_resp_rdata, 32'h0);
        check("rst_a_req_ready", 32'(a_req_ready), 32'h0);
        check("rst_b_resp_valid", 32'(b_resp_valid), 32'h0);
        check("rst_b_req_ready", 32'(b_req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_release_ready_low", 32'(a_req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("first_edge_ready_a", 32'(a_req_ready), 32'h1);
        check("first_edge_ready_b", 32'(b_req_ready), 32'h1);

        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        check("write_read_const", rd, 32'hDEAD_BEEF);

        applyStimulus(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, rd);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        check("strobe_const", rd, 32'hDE22_BE44);

        applyStimulus(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd);
        applyStimulus(0, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0, rd);
        applyStimulus(0, 1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0, rd);
        applyStimulus(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, rd);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        check("err_write_no_change", rd, 32'hDE22_BE44);

        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd);

        for (int w = 0; w < 16; w++) begin
            applyStimulus(0, 1'b1, 32'(4 * w), $urandom, 4'hF, 0, rd);
        end
        for (int n = 0; n < 30; n++) begin
            applyStimulus(0, 1'($urandom), pick_addr(0, 15), $urandom,
                          4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), rd);
        end

        applyStimulus(0, 1'b1, 32'h20, 32'h0, 4'hF, 0, rd);
        @(negedge clk);
        req_we      = 1'b1;
        req_addr    = 32'h20;
        req_wdata   = 32'hCAFE_F00D;
        req_wstrb   = 4'hF;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_resp_valid", 32'(a_resp_valid), 32'h0);
        check("abort_req_ready", 32'(a_req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("abort_no_response", 32'(a_resp_valid), 32'h0);
        end
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        check("abort_not_committed", rd, 32'h0);

        applyStimulus(1, 1'b1, 32'h40, 32'h0BAD_CAFE, 4'hF, 0, rd);
        applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd);
        check("zero_lat_read_const", rd, 32'h0BAD_CAFE);
        for (int w = 16; w < 24; w++) begin
            applyStimulus(1, 1'b1, 32'(4 * w), $urandom, 4'hF, 0, rd);
        end
        for (int n = 0; n < 15; n++) begin
            applyStimulus(1, 1'($urandom), pick_addr(16, 23), $urandom,
                          4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
